// File: rtl/run_seq_pkg.sv
// Shared types for the run sequencer: controller state and run status.
package run_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    RUN,
    RD,
    OUT,
    DONE
  } state_t;

  // Default cycle-counter width. The status view below uses it.
  localparam int unsigned STATUS_CW = 16;

  typedef struct packed {
    logic                 timeout;
    logic [STATUS_CW-1:0] cycles;
  } run_status_t;

endpackage

// File: rtl/run_sequencer.sv
// Run controller: load an image into data memory with the core held in
// reset, kick the core and time it, then stream a window of memory back out.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned MA         = 8,
  parameter int unsigned CW         = STATUS_CW,
  parameter int unsigned MAX_CYCLES = 4096,
  parameter int unsigned DUMP_BASE  = 0,
  parameter int unsigned DUMP_COUNT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [MA-1:0] load_addr,
  input  logic [W-1:0]  load_data,
  input  logic          load_last,
  output logic          core_rst,
  output logic          core_req,
  input  logic          core_done,
  output logic          mem_we,
  output logic [MA-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  input  logic [W-1:0]  mem_rdata,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [W-1:0]  dump_data,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  typedef struct packed {
    logic          timeout;
    logic [CW-1:0] cycles;
  } status_t;

  localparam logic [CW-1:0] LAST_RUN_CYC = CW'(MAX_CYCLES - 1);
  localparam logic [MA-1:0] BASE_ADDR    = MA'(DUMP_BASE);
  localparam logic [MA-1:0] LAST_IDX     = MA'(DUMP_COUNT - 1);

  state_t        state;
  state_t        state_nx;
  status_t       status;
  logic [MA-1:0] idx;
  logic          have;      // dump_data holds a captured word for this OUT visit
  logic [W-1:0]  hold;
  logic          fin_q;

  logic          run_expire;
  logic          dump_hs;
  logic          dump_last;
  logic [MA-1:0] rd_addr;

  assign run_expire = (status.cycles == LAST_RUN_CYC);
  assign dump_hs    = (state == OUT) && have && dump_ready;
  assign dump_last  = (idx == LAST_IDX);
  assign rd_addr    = BASE_ADDR + idx;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = LOAD;
        LOAD:    if (load_valid && load_last) state_nx = KICK;
        KICK:    state_nx = RUN;
        RUN:     if (core_done || run_expire) state_nx = RD;
        RD:      state_nx = OUT;
        OUT:     if (dump_hs) state_nx = dump_last ? DONE : RD;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Counters, run status and the dump holding register.
  // OUT spends its first cycle capturing mem_rdata (address was issued in RD,
  // memory answers one cycle later), so dump_valid rises on the second cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      status <= '0;
      idx    <= '0;
      have   <= 1'b0;
      hold   <= '0;
      fin_q  <= 1'b0;
    end else begin
      fin_q <= (state == DONE) && !abort;
      if (abort) begin
        have <= 1'b0;
      end else begin
        case (state)
          KICK: begin
            status <= '0;
            idx    <= '0;
          end
          RUN: begin
            status.cycles <= status.cycles + CW'(1);
            if (run_expire && !core_done) status.timeout <= 1'b1;
          end
          OUT: begin
            if (!have) begin
              hold <= mem_rdata;
              have <= 1'b1;
            end else if (dump_ready) begin
              have <= 1'b0;
              idx  <= idx + MA'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Per-state outputs; everything defaults low except core_rst.
  always_comb begin
    core_rst   = 1'b1;
    core_req   = 1'b0;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    dump_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      LOAD: begin
        load_ready = 1'b1;
        mem_we     = load_valid;
        mem_addr   = load_addr;
        mem_wdata  = load_data;
      end
      KICK: begin
        core_rst = 1'b0;
        core_req = 1'b1;
      end
      RUN:     core_rst = 1'b0;
      RD:      mem_addr = rd_addr;
      OUT:     dump_valid = have;
      default: ;
    endcase
  end

  assign dump_data = hold;
  assign finished  = fin_q;
  assign timeout   = status.timeout;
  assign cycles    = status.cycles;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer with a memory, a core stub and a
// reference image of what each dump must return.
module tb_run_sequencer;
  import run_seq_pkg::*;

  localparam int unsigned W    = 8;
  localparam int unsigned MA   = 8;
  localparam int unsigned CW   = 16;
  localparam int unsigned MAXC = 32;
  localparam int unsigned BASE = 254;
  localparam int unsigned CNT  = 4;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic          load_valid, load_ready, load_last;
  logic [MA-1:0] load_addr;
  logic [W-1:0]  load_data;
  logic          core_rst, core_req, core_done;
  logic          mem_we;
  logic [MA-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata;
  logic          dump_valid, dump_ready;
  logic [W-1:0]  dump_data;
  logic          busy, finished, timeout;
  logic [CW-1:0] cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  run_sequencer #(
    .W(W), .MA(MA), .CW(CW), .MAX_CYCLES(MAXC),
    .DUMP_BASE(BASE), .DUMP_COUNT(CNT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .load_last(load_last),
    .core_rst(core_rst), .core_req(core_req), .core_done(core_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .busy(busy), .finished(finished), .timeout(timeout), .cycles(cycles)
  );

  // Data memory with one-cycle read latency.
  logic [W-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Core stub: raises done in the done_after-th cycle following req (0 = never).
  int core_cnt   = 0;
  int done_after = 0;
  always @(posedge clk) begin
    if (core_req)           core_cnt <= 1;
    else if (core_cnt != 0) core_cnt <= core_cnt + 1;
  end
  assign core_done = (done_after != 0) && (core_cnt == done_after);

  // Reference image of everything the bench has loaded.
  logic [W-1:0] ref_mem [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full load/run/dump pass. d = core done delay (0 = never),
  // stall_word = dump word on which dump_ready is held low for 5 cycles.
  task automatic do_run(input int d, input int stall_word);
    logic [MA-1:0] addrs[$];
    logic [MA-1:0] a;
    logic [W-1:0]  v;
    logic [W-1:0]  held;
    int            nexp;
    int            lat;
    int            guard;
    int            nextra;
    run_status_t   st_exp;
    done_after = d;
    check("idle_busy", busy, 0);
    check("idle_core_rst", core_rst, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_ready", load_ready, 1);
    check("load_busy", busy, 1);

    addrs = {};
    for (int i = 0; i < CNT; i++) addrs.push_back(MA'(BASE + i));
    nextra = $urandom_range(0, 3);
    for (int i = 0; i < nextra; i++) addrs.insert($urandom_range(0, addrs.size()), MA'($urandom));

    for (int i = 0; i < addrs.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        load_last  = $urandom_range(0, 1) == 1;
        load_addr  = MA'($urandom);
        #1;
        check("we_idle", mem_we, 0);
        tick();
        check("stay_load", load_ready, 1);
      end
      a = addrs[i];
      v = W'($urandom);
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = v;
      load_last  = (i == addrs.size() - 1);
      #1;
      check("load_we", mem_we, 1);
      check("load_waddr", mem_addr, a);
      check("load_wdata", mem_wdata, v);
      ref_mem[a] = v;
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("kick_req", core_req, 1);
    check("kick_core_rst", core_rst, 0);

    nexp = (d == 0 || d > MAXC) ? MAXC : d;
    lat = 0;
    while (!dump_valid && lat < 200) begin
      tick();
      lat++;
      if (lat == 1) begin
        check("req_one_cycle", core_req, 0);
        check("run_core_rst", core_rst, 0);
      end
    end
    check("dump_latency", lat, nexp + 3);

    for (int i = 0; i < CNT; i++) begin
      guard = 0;
      while (!dump_valid && guard < 20) begin
        tick();
        guard++;
      end
      check("dump_valid", dump_valid, 1);
      check("dump_core_rst", core_rst, 1);
      check("dump_word", dump_data, ref_mem[MA'(BASE + i)]);
      if (i == stall_word) begin
        held = dump_data;
        dump_ready = 1'b0;
        repeat (5) begin
          tick();
          check("stall_valid", dump_valid, 1);
          check("stall_data", dump_data, held);
        end
      end
      dump_ready = 1'b1;
      tick();
      dump_ready = 1'b0;
      check("valid_after_hs", dump_valid, 0);
    end

    check("done_busy", busy, 1);
    check("done_no_finished", finished, 0);
    tick();
    check("finished_pulse", finished, 1);
    check("end_busy", busy, 0);
    st_exp.timeout = (d == 0 || d > MAXC);
    st_exp.cycles  = CW'(nexp);
    check("status", {timeout, cycles}, st_exp);
    tick();
    check("finished_once", finished, 0);
  endtask

  initial begin
    logic          t_keep;
    logic [CW-1:0] c_keep;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    load_valid = 1'b0; load_last = 1'b0; load_addr = '0; load_data = '0;
    dump_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_core_req", core_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_dump_valid", dump_valid, 0);
    check("rst_finished", finished, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cycles", cycles, 0);
    check("rst_dump_data", dump_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    tick();

    do_run(10, 1);
    do_run(0, -1);
    do_run(32, 2);
    do_run($urandom_range(1, 31), $urandom_range(0, 3));

    // Abort mid-LOAD: back to IDLE, status of the previous run retained.
    t_keep = timeout;
    c_keep = cycles;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_valid = 1'b1; load_addr = 8'd9; load_data = 8'h5a; load_last = 1'b0;
    ref_mem[8'd9] = 8'h5a;
    tick();
    load_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_load_ready", load_ready, 0);
    check("abort_core_rst", core_rst, 1);
    check("abort_finished", finished, 0);
    check("abort_timeout", timeout, t_keep);
    check("abort_cycles", cycles, c_keep);
    tick();
    check("abort_no_finished", finished, 0);

    // Synchronous reset in the middle of RUN.
    done_after = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_valid = 1'b1; load_addr = 8'd20; load_data = 8'h33; load_last = 1'b1;
    ref_mem[8'd20] = 8'h33;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    repeat (6) tick();
    check("mid_run_core_rst", core_rst, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_busy", busy, 0);
    check("mr_core_rst", core_rst, 1);
    check("mr_core_req", core_req, 0);
    check("mr_cycles", cycles, 0);
    check("mr_timeout", timeout, 0);
    check("mr_dump_valid", dump_valid, 0);
    check("mr_mem_addr", mem_addr, 0);
    tick();

    do_run(5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
